// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and register-file write-back formatter (optional trace ports: WB_TRACE_EN)
module mem_wb_stage #(
    parameter int n = 32,
    parameter int m = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         mem_valid,
    input  logic         mem_regwrite,
    input  logic         mem_to_reg,
    input  logic [2:0]   mem_load_type,
    input  logic [m-1:0] mem_waddr,
    input  logic [n-1:0] mem_alu_result,
    input  logic [n-1:0] mem_rdata,
`ifdef WB_TRACE_EN
    input  logic [n-1:0] mem_pc,
    output logic [n-1:0] debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [m-1:0] debug_wb_rf_wnum,
    output logic [n-1:0] debug_wb_rf_wdata,
`endif
    output logic [m-1:0] RF_address_write,
    output logic [n-1:0] RF_data_write,
    output logic         RFWr,
    output logic         wb_misalign,
    output logic [31:0]  wb_retired
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic         r_valid;
    logic         r_regwrite;
    logic         r_to_reg;
    logic [2:0]   r_load_type;
    logic [m-1:0] r_waddr;
    logic [n-1:0] r_alu;
    logic [n-1:0] r_rdata;
    logic [31:0]  r_retired;
`ifdef WB_TRACE_EN
    logic [n-1:0] r_pc;
`endif

    logic [1:0]   w_off;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic         w_is_lb;
    logic         w_is_lbu;
    logic         w_is_lh;
    logic         w_is_lhu;
    logic         w_is_lw;
    logic [n-1:0] w_load_data;
    logic         w_misalign;

    // Pipeline register: reset clears, flush inserts a bubble (beats stall), stall holds, else capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_to_reg    <= 1'b0;
            r_load_type <= 3'b000;
            r_waddr     <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= mem_valid;
            r_regwrite  <= mem_regwrite;
            r_to_reg    <= mem_to_reg;
            r_load_type <= mem_load_type;
            r_waddr     <= mem_waddr;
            r_alu       <= mem_alu_result;
            r_rdata     <= mem_rdata;
        end
    end

`ifdef WB_TRACE_EN
    // Trace PC follows the same reset/flush/stall/capture rules as the other fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (!flush && !stall) begin
            r_pc <= mem_pc;
        end
    end
`endif

    // Retired counter: the entry leaving WB counts whenever the stage advances, even if its write is suppressed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_valid && !stall) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Load alignment, extension and write-enable qualification, purely from registered state
    always_comb begin
        w_off    = r_alu[1:0];
        w_is_lb  = (r_load_type == LT_LB);
        w_is_lbu = (r_load_type == LT_LBU);
        w_is_lh  = (r_load_type == LT_LH);
        w_is_lhu = (r_load_type == LT_LHU);
        w_is_lw  = !(w_is_lb || w_is_lbu || w_is_lh || w_is_lhu);

        case (w_off)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

        if (w_is_lb) begin
            w_load_data = {{(n-8){w_byte[7]}}, w_byte};
        end else if (w_is_lbu) begin
            w_load_data = {{(n-8){1'b0}}, w_byte};
        end else if (w_is_lh) begin
            w_load_data = {{(n-16){w_half[15]}}, w_half};
        end else if (w_is_lhu) begin
            w_load_data = {{(n-16){1'b0}}, w_half};
        end else begin
            w_load_data = r_rdata;
        end

        w_misalign = r_valid && r_to_reg &&
                     ((w_is_lw && (w_off != 2'd0)) || ((w_is_lh || w_is_lhu) && w_off[0]));
    end

    assign RF_address_write = r_waddr;
    assign RF_data_write    = r_to_reg ? w_load_data : r_alu;
    // The register file does not guard $0, so the write is dropped here
    assign RFWr             = r_valid && r_regwrite && (r_waddr != '0) && !w_misalign;
    assign wb_misalign      = w_misalign;
    assign wb_retired       = r_retired;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{RFWr}};
    assign debug_wb_rf_wnum  = r_waddr;
    assign debug_wb_rf_wdata = RF_data_write;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_regwrite;
    logic        mem_to_reg;
    logic [2:0]  mem_load_type;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rdata;
    logic [4:0]  RF_address_write;
    logic [31:0] RF_data_write;
    logic        RFWr;
    logic        wb_misalign;
    logic [31:0] wb_retired;
`ifdef WB_TRACE_EN
    logic [31:0] mem_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.n(32), .m(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .mem_valid        (mem_valid),
        .mem_regwrite     (mem_regwrite),
        .mem_to_reg       (mem_to_reg),
        .mem_load_type    (mem_load_type),
        .mem_waddr        (mem_waddr),
        .mem_alu_result   (mem_alu_result),
        .mem_rdata        (mem_rdata),
`ifdef WB_TRACE_EN
        .mem_pc           (mem_pc),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .RF_address_write (RF_address_write),
        .RF_data_write    (RF_data_write),
        .RFWr             (RFWr),
        .wb_misalign      (wb_misalign),
        .wb_retired       (wb_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic tr, input logic [2:0] lt,
                         input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd);
        mem_valid      = v;
        mem_regwrite   = rw;
        mem_to_reg     = tr;
        mem_load_type  = lt;
        mem_waddr      = wa;
        mem_alu_result = alu;
        mem_rdata      = rd;
`ifdef WB_TRACE_EN
        mem_pc         = alu ^ 32'h0040_0000;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick(); tick();
        chk("reset_addr", {27'd0, RF_address_write}, 32'd0);
        chk("reset_data", RF_data_write, 32'd0);
        chk("reset_wen", {31'd0, RFWr}, 32'd0);
        chk("reset_mis", {31'd0, wb_misalign}, 32'd0);
        chk("reset_ret", wb_retired, 32'd0);

        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd5, 32'h0000_1003, 32'h80FF_1234);
        tick();
        chk("lb_data", RF_data_write, 32'hFFFF_FF80);
        chk("lb_addr", {27'd0, RF_address_write}, 32'd5);
        chk("lb_wen", {31'd0, RFWr}, 32'd1);
        chk("lb_ret0", wb_retired, 32'd0);

        drive(1'b1, 1'b1, 1'b1, 3'b100, 5'd6, 32'h0000_2002, 32'h9ABC_0001);
        tick();
        chk("lhu_data", RF_data_write, 32'h0000_9ABC);
        chk("lb_ret1", wb_retired, 32'd1);

        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd6, 32'h0000_2002, 32'h9ABC_0001);
        tick();
        chk("lh_data", RF_data_write, 32'hFFFF_9ABC);
        chk("lh_wen", {31'd0, RFWr}, 32'd1);
        chk("ret2", wb_retired, 32'd2);

        drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_3001, 32'h1111_2222);
        tick();
        chk("lw_mis_flag", {31'd0, wb_misalign}, 32'd1);
        chk("lw_mis_wen", {31'd0, RFWr}, 32'd0);
        chk("ret3", wb_retired, 32'd3);

        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd0, 32'h0000_1234, 32'hAAAA_AAAA);
        tick();
        chk("r0_wen", {31'd0, RFWr}, 32'd0);
        chk("r0_data", RF_data_write, 32'h0000_1234);
        chk("r0_mis", {31'd0, wb_misalign}, 32'd0);
        chk("mis_counted", wb_retired, 32'd4);

        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd9, 32'hDEAD_BEEF, 32'h0);
        tick();
        chk("alu_data", RF_data_write, 32'hDEAD_BEEF);
        chk("alu_wen", {31'd0, RFWr}, 32'd1);
        chk("r0_counted", wb_retired, 32'd5);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd10 + 5'(i), 32'h55 + 32'(i), 32'hCAFE_0000);
            tick();
            chk("stall_data", RF_data_write, 32'hDEAD_BEEF);
            chk("stall_addr", {27'd0, RF_address_write}, 32'd9);
            chk("stall_wen", {31'd0, RFWr}, 32'd1);
            chk("stall_ret", wb_retired, 32'd5);
        end

        flush = 1'b1;
        tick();
        chk("flush_wen", {31'd0, RFWr}, 32'd0);
        chk("flush_valid", {31'd0, dut.r_valid}, 32'd0);
        chk("flush_ret", wb_retired, 32'd5);

        flush = 1'b0; stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd3, 32'h0000_0077, 32'h0);
        tick();
        chk("bubble_not_counted", wb_retired, 32'd5);
        chk("post_flush_data", RF_data_write, 32'h0000_0077);

        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd8, 32'h0000_1002, 32'h80FF_1234);
        tick();
        chk("lbu_data", RF_data_write, 32'h0000_00FF);
        chk("ret6", wb_retired, 32'd6);

        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd8, 32'h0000_1001, 32'h80FF_1234);
        tick();
        chk("lh_mis_flag", {31'd0, wb_misalign}, 32'd1);
        chk("lh_mis_wen", {31'd0, RFWr}, 32'd0);

        drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd11, 32'h0000_4000, 32'h1234_5678);
        tick();
        chk("lw_data", RF_data_write, 32'h1234_5678);
        chk("lw_wen", {31'd0, RFWr}, 32'd1);

        stall = 1'b1; rst = 1'b1;
        tick();
        chk("rst_stall_wen", {31'd0, RFWr}, 32'd0);
        chk("rst_stall_data", RF_data_write, 32'd0);
        chk("rst_stall_addr", {27'd0, RF_address_write}, 32'd0);
        chk("rst_stall_ret", wb_retired, 32'd0);

        rst = 1'b0; stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'h0000_0001, 32'h0);
        tick();
        chk("post_rst_wen", {31'd0, RFWr}, 32'd1);
        chk("post_rst_ret", wb_retired, 32'd0);

        stall = 1'b1;
        @(negedge clk);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        #1;
        chk("preset_ret", wb_retired, 32'hFFFF_FFFF);
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        tick();
        chk("wrap_ret", wb_retired, 32'd0);
        tick();
        chk("idle_ret", wb_retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
